// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: width defaults
// and the encoding of the two writeback sources.
package rf_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 2;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Issue, writeback-source, hazard-check and register-file write signals of
// the writeback arbiter.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_waddr;
  logic              issue_ready;

  logic              a_valid;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_waddr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ready;

  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              stall;

  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output issue_valid, issue_waddr,
    input  issue_ready,
    output a_valid, a_waddr, a_wdata,
    input  a_ready,
    output b_valid, b_waddr, b_wdata,
    input  b_ready,
    output raddr1, raddr2,
    input  stall,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  issue_valid, issue_waddr,
    output issue_ready,
    input  a_valid, a_waddr, a_wdata,
    output a_ready,
    input  b_valid, b_waddr, b_wdata,
    output b_ready,
    input  raddr1, raddr2,
    output stall,
    output rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on contention the source not granted
// last wins. Grants are suppressed while reset is asserted.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  src_e last_q;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (rst_ni) begin
      if (req_a_i && (!req_b_i || last_q == SRC_B)) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= SRC_B;
    end else if (gnt_a_o) begin
      last_q <= SRC_A;
    end else if (gnt_b_o) begin
      last_q <= SRC_B;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges two result sources into one register-file write
// port and tracks pending writes per register for read-hazard stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_arbiter_if.slave  bus
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  logic gnt_a, gnt_b;

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [NREG-1:0]   inc_vec, dec_vec;
  logic              issue_fire;

  logic              rf_wen_q,   rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  rr_arb2 u_arb (
    .clk_i   (clk),
    .rst_ni  (rst),
    .req_a_i (bus.a_valid),
    .req_b_i (bus.b_valid),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;

  // r0 is always accepted and never counted, so it can neither block nor stall.
  assign bus.issue_ready = rst && (bus.issue_waddr == '0 || cnt_q[bus.issue_waddr] != '1);
  assign issue_fire      = bus.issue_valid && bus.issue_ready && bus.issue_waddr != '0;

  assign bus.stall = (bus.raddr1 != '0 && cnt_q[bus.raddr1] != '0) ||
                     (bus.raddr2 != '0 && cnt_q[bus.raddr2] != '0);

  // A write retires its pending entry only in the cycle rf_wen is high.
  always_comb begin
    inc_vec = issue_fire ? (ONE_HOT0 << bus.issue_waddr) : '0;
    dec_vec = rf_wen_q   ? (ONE_HOT0 << rf_waddr_q)      : '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_a) begin
      rf_wen_d   = bus.a_waddr != '0;
      rf_waddr_d = bus.a_waddr;
      rf_wdata_d = bus.a_wdata;
    end else if (gnt_b) begin
      rf_wen_d   = bus.b_waddr != '0;
      rf_waddr_d = bus.b_waddr;
      rf_wdata_d = bus.b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then random traffic, all checked
// against a pending-count/round-robin reference model.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding writes per register, who won last, next write.
  int          pend [32];
  bit          last_b;
  bit          e_wen;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  // Observations from the most recent step, for directed spot checks.
  logic o_a, o_b, o_ir, o_st;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    last_b  = 1'b1;
    e_wen   = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
  endtask

  task automatic step(input bit rstn,
                      input bit iv, input logic [4:0] ia,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit er, eag, ebg, est, inc;
    @(negedge clk);
    rst             = rstn;
    bus.issue_valid = iv;  bus.issue_waddr = ia;
    bus.a_valid     = av;  bus.a_waddr = aa;  bus.a_wdata = ad;
    bus.b_valid     = bv;  bus.b_waddr = ba;  bus.b_wdata = bd;
    bus.raddr1      = r1;  bus.raddr2 = r2;
    #1;
    er  = rstn && (ia == 0 || pend[ia] < 3);
    eag = rstn && av && (!bv || last_b);
    ebg = rstn && bv && (!av || !last_b);
    est = (r1 != 0 && pend[r1] > 0) || (r2 != 0 && pend[r2] > 0);
    o_a = bus.a_ready; o_b = bus.b_ready; o_ir = bus.issue_ready; o_st = bus.stall;
    chk("issue_ready", o_ir, er);
    chk("a_ready", o_a, eag);
    chk("b_ready", o_b, ebg);
    chk("stall", o_st, est);

    if (!rstn) begin
      model_reset();
    end else begin
      inc = iv && er && ia != 0;
      if (!(inc && e_wen && e_waddr == ia)) begin
        if (inc) pend[ia]++;
        if (e_wen && pend[e_waddr] > 0) pend[e_waddr]--;
      end
      if (eag) begin
        last_b = 1'b0; e_wen = (aa != 0); e_waddr = aa; e_wdata = ad;
      end else if (ebg) begin
        last_b = 1'b1; e_wen = (ba != 0); e_waddr = ba; e_wdata = bd;
      end else begin
        e_wen = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    chk("rf_wen", bus.rf_wen, e_wen);
    if (e_wen || !rstn) begin
      chk("rf_waddr", bus.rf_waddr, e_waddr);
      chk("rf_wdata", bus.rf_wdata, e_wdata);
    end
  endtask

  task automatic idle(input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2);
    step(1, 0, ia, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic awrite(input logic [4:0] aa, input logic [31:0] ad);
    step(1, 0, 0, 1, aa, ad, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    bus.issue_valid = 0; bus.issue_waddr = 0;
    bus.a_valid = 0; bus.a_waddr = 0; bus.a_wdata = 0;
    bus.b_valid = 0; bus.b_waddr = 0; bus.b_wdata = 0;
    bus.raddr1 = 0; bus.raddr2 = 0;

    step(0, 1, 4, 1, 4, 32'h11, 1, 5, 32'h22, 4, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_rf_wen", bus.rf_wen, 1'b0);

    // Issue r5, write it from A, watch the hazard clear after the write.
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
    step(1, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
    chk("r17_a_ready", o_a, 1'b1);
    chk("r17_stall_pre", o_st, 1'b1);
    chk("r17_wdata", bus.rf_wdata, 32'h1234);
    idle(0, 5, 0);
    chk("r17_stall_wen_cycle", o_st, 1'b1);
    idle(0, 5, 0);
    chk("r17_stall_after", o_st, 1'b0);

    // Contention right after reset alternates starting with A.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 1, 5'd1, 32'hA0 + k, 1, 5'd2, 32'hB0 + k, 0, 0);
      chk("r18_grant_a", o_a, (k % 2) == 0);
      chk("r18_waddr", bus.rf_waddr, (k % 2) == 0 ? 5'd1 : 5'd2);
    end

    // Saturate r7, then drain it.
    for (int k = 0; k < 3; k++) step(1, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("r19_full", o_ir, 1'b0);
    awrite(7, 32'h70);
    idle(7, 7, 0);
    chk("r19_full_wen_cycle", o_ir, 1'b0);
    idle(7, 7, 0);
    chk("r19_ready_again", o_ir, 1'b1);
    awrite(7, 32'h71);
    idle(7, 7, 0);
    idle(7, 7, 0);
    chk("r19_stall_two_done", o_st, 1'b1);
    awrite(7, 32'h72);
    idle(7, 7, 0);
    idle(7, 7, 0);
    chk("r19_stall_three_done", o_st, 1'b0);

    // Writes to r0 are handshaked but never reach the register file.
    step(1, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    chk("r20_b_ready", o_b, 1'b1);
    chk("r20_stall_r0", o_st, 1'b0);
    chk("r20_no_write", bus.rf_wen, 1'b0);

    // Re-issue r3 in the cycle its earlier write retires.
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3);
    awrite(3, 32'h33);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3);
    idle(0, 0, 3);
    chk("r21_stall_kept", o_st, 1'b1);

    // Reset with work in flight.
    step(1, 1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 9);
    chk("r22_a_ready_rst", o_a, 1'b0);
    step(0, 1, 9, 1, 9, 32'h99, 1, 3, 32'h98, 9, 3);
    chk("r22_stall_cleared", o_st, 1'b0);
    chk("r22_issue_ready_rst", o_ir, 1'b0);
    step(1, 0, 0, 1, 1, 32'h1, 1, 2, 32'h2, 0, 0);
    chk("r22_a_first", o_a, 1'b1);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameters: DATA_W, 32, write-data width; ADDR_W, 5, register-address width; CNT_W, 2, per-register pending-write counter width.
REQ-002 SHALL have ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-low reset
issue_valid  in  1  decode issues an instruction with a destination register
issue_waddr  in  ADDR_W  destination of the issued instruction
issue_ready  out  1  the issue is accepted this cycle
a_valid  in  1  source A (ALU writeback) has a result
a_waddr  in  ADDR_W  source A destination
a_wdata  in  DATA_W  source A data
a_ready  out  1  source A is granted this cycle
b_valid  in  1  source B (load/mul-div writeback) has a result
b_waddr  in  ADDR_W  source B destination
b_wdata  in  DATA_W  source B data
b_ready  out  1  source B is granted this cycle
raddr1  in  ADDR_W  read port 1 address under hazard check
raddr2  in  ADDR_W  read port 2 address under hazard check
stall  out  1  a read operand has a pending write
rf_wen  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data

Function
REQ-003 SHALL grant at most one source per cycle; grant = valid && ready; a_ready/b_ready combinational from valids and arbitration state.
REQ-004 SHALL arbitrate round-robin: single valid wins; both valid -> source not granted last; last_grant flips only on a grant.
REQ-005 SHALL register the granted request into rf_wen/rf_waddr/rf_wdata at the next rising edge (1-cycle latency); no grant -> rf_wen=0 next cycle.
REQ-006 SHALL complete a granted handshake with waddr=0 but drive rf_wen=0 (register 0 never written).
REQ-007 SHALL keep a CNT_W-bit pending counter per register; issue handshake increments cnt[issue_waddr]; a performed write (rf_wen=1) decrements cnt[rf_waddr].
REQ-008 SHALL leave the counter unchanged when increment and decrement hit the same register in one cycle.
REQ-009 SHALL drive issue_ready=0 when cnt[issue_waddr] is at maximum (3), else 1; issue_waddr=0 SHALL be accepted without counting.
REQ-010 SHALL never decrement a zero counter; a write to a register with cnt=0 is performed and the counter stays 0.
REQ-011 SHALL drive stall = (raddr1!=0 && cnt[raddr1]!=0) || (raddr2!=0 && cnt[raddr2]!=0), combinational.
REQ-012 SHALL count a write as completed only on the cycle rf_wen=1, so stall drops the cycle the register file actually updates (no forwarding provided).

Reset
REQ-013 SHALL, on rst=0 at a rising edge: all counters 0, last_grant=B (A wins first contention), rf_wen=0, rf_waddr=0, rf_wdata=0.
REQ-014 SHALL, while rst=0, drive a_ready=0, b_ready=0, issue_ready=0; requests in flight are dropped, not replayed.

Structure
REQ-015 SHALL place DATA_W/ADDR_W/CNT_W defaults and the source-select encoding (SRC_A=0, SRC_B=1) in a shared cpu package.
REQ-016 SHALL instantiate one sub-module, rr_arb2 (two-requester round-robin arbiter with last-grant register); counters and output stage stay in the top.

Verification
REQ-017 Issue r5, then a_valid waddr=5 wdata=0x1234 -> a_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234; stall for raddr1=5 high until that cycle, low after.
REQ-018 a_valid and b_valid together 4 cycles after reset -> grants A,B,A,B; rf_waddr sequence matches.
REQ-019 Issue r7 three times -> fourth issue_ready=0; one write to r7 -> issue_ready=1 next cycle; cnt reaches 0 only after three writes.
REQ-020 b_valid waddr=0 wdata=0xFFFFFFFF -> b_ready=1, rf_wen stays 0; stall with raddr1=raddr2=0 always 0.
REQ-021 Issue r3 on the cycle rf_wen=1 rf_waddr=3 with cnt[3]=1 -> cnt[3] stays 1, stall for raddr2=3 stays 1.
REQ-022 Assert rst=0 with pending counts and a_valid=1 -> next cycle all ready low, rf_wen=0, stall=0 for any raddr; after release A wins first contention.
